case_convert_stream: RTL and testbench
======================================

# case_convert_stream

Streaming ASCII case converter: successor to the single-byte combinational upper-case block. Accepts `LANES` bytes per beat over a valid/ready handshake and converts each byte according to a runtime mode: pass, upper, lower or toggle. Only true letters are touched. The result is registered, with a skid buffer to sustain full throughput under backpressure. Sits between the byte-stream source (UART/text ingress) and downstream consumers.

## Interface
Parameters:
- `LANES`, 4: bytes per beat (≥1); data width is 8·LANES, byte 0 at bits [7:0].
- `CNT_W`, 16: width of the conversion counter.

Ports:
- `clk`  in  1: clock.
- `rst_n`  in  1: reset. One clock; reset is synchronous and active-low.
- `mode`  in  2: 00 pass, 01 upper, 10 lower, 11 toggle; sampled per beat on acceptance.
- `in_valid`  in  1: input beat valid.
- `in_ready`  out  1: block can accept.
- `in_data`  in  8·LANES: input bytes.
- `in_last`  in  1: end-of-message marker; carried through unchanged.
- `out_valid`  out  1: output beat valid.
- `out_ready`  in  1: consumer accepts.
- `out_data`  out  8·LANES: converted bytes.
- `out_last`  out  1: delayed `in_last`.
- `count_clr`  in  1: clears `conv_count`.
- `conv_count`  out  CNT_W: saturating count of bytes modified.

## Operation
- Acceptance: `in_valid && in_ready` at a rising edge. Emission: `out_valid && out_ready`.
- Per byte b:
  - Upper letter: 0x41–0x5A. Lower letter: 0x61–0x7A.
  - upper: lower letter → b−0x20.
  - lower: upper letter → b+0x20.
  - toggle: any letter → b XOR 0x20.
  - pass: unchanged.
  - All non-letters (digits, punctuation, 0x80–0xFF, 0x40, 0x5B, 0x60, 0x7B) always pass unchanged.
  - Bit 7 is never altered.
- Storage: output register (OUT) plus one skid register (SKID). No other state.
  - Accept while OUT is empty or being emitted: converted beat goes to OUT.
  - Accept while OUT is full and not emitted: converted beat goes to SKID.
  - Emission while SKID is full: SKID moves to OUT and SKID empties.
- `in_ready` = !SKID_full, taken from registers only; no combinational path from `out_ready`.
- Conversion is applied on acceptance, so a beat held in SKID keeps the mode it was accepted with.
- Counter:
  - On acceptance, adds the number of bytes actually modified in that beat (0..LANES).
  - Saturates at 2^CNT_W−1; never wraps.
  - `count_clr` and acceptance in the same cycle: counter loads that beat's contribution only.
  - `count_clr` alone: counter becomes 0.

## Timing
- Reset (rst_n low at an edge):
  - `out_valid`=0, `out_data`=0, `out_last`=0.
  - SKID empty, `conv_count`=0.
  - `in_ready` is forced 0 while `rst_n` is low and is 1 on the first cycle after release.
- Reset mid-stream discards OUT and SKID contents without emitting them.
- Latency: a beat accepted at edge N is valid on `out_valid` after edge N, i.e. 1 cycle.
- Throughput: 1 beat/cycle while `out_ready`=1.
- Backpressure: with `out_ready`=0, one further beat is absorbed into SKID; `in_ready` falls the cycle after.
- After `out_ready` returns, `in_ready` rises the cycle after the first emission.
- `out_data`/`out_last` hold stable while `out_valid && !out_ready`.
- `conv_count` reflects a beat's contribution the cycle after its acceptance.

## Configuration
- `CASE_CONV_STATS_EN` defined: counter logic present as described.
- Undefined: counter logic absent, `conv_count` tied to 0, `count_clr` ignored.
- The port list is identical in both cases.

## Structure
- Package `case_conv_pkg`:
  - `case_mode_t` enum (MODE_PASS, MODE_UPPER, MODE_LOWER, MODE_TOGGLE).
  - Constants ASCII_UC_LO=0x41, ASCII_UC_HI=0x5A, ASCII_LC_LO=0x61, ASCII_LC_HI=0x7A, CASE_BIT=5.
- Sub-module `case_conv_lane`: combinational single byte in, mode in, converted byte out plus a `modified` flag.
  - Instantiated LANES times by generate.
  - Flags are summed with a popcount into the counter.

## Test plan
- Reset, LANES=4, mode=upper, `in_data`=0x7A_61_5A_41 ("AZaz"), `out_ready`=1 → next cycle `out_data`=0x5A_41_5A_41, `conv_count`=2.
- mode=lower, bytes 0x40,0x5B,0x60,0x7B → output identical to input, `conv_count` unchanged.
- mode=toggle, 0x00_31_62_41 → 0x00_31_42_61, `conv_count`+2; mode=pass on the same data → unchanged, +0.
- `out_ready`=0, three consecutive valid beats:
  - Beats 1 and 2 accepted, `in_ready`=0 on the third cycle.
  - Raise `out_ready` → beats emitted in order, `out_last` preserved, no loss or duplication.
- With `CASE_CONV_STATS_EN`, CNT_W=4: 5 beats of 4 lowercase letters in upper mode → `conv_count` saturates at 15; `count_clr` together with a 2-letter beat → 2.
- Assert `rst_n`=0 with OUT and SKID full → next cycle `out_valid`=0, `conv_count`=0; after release `in_ready`=1.

Source files
------------

// File: rtl/case_conv_pkg.sv
// case_conv_pkg
// Shared types and constants for the streaming ASCII case converter.
//   case_mode_t : per-beat conversion mode (pass / upper / lower / toggle)
//   ASCII_*     : inclusive bounds of the upper- and lower-case letter ranges
//   CASE_BIT    : the bit that distinguishes upper from lower case
package case_conv_pkg;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'b00,
        MODE_UPPER  = 2'b01,
        MODE_LOWER  = 2'b10,
        MODE_TOGGLE = 2'b11
    } case_mode_t;

    localparam logic [7:0] ASCII_UC_LO = 8'h41;
    localparam logic [7:0] ASCII_UC_HI = 8'h5A;
    localparam logic [7:0] ASCII_LC_LO = 8'h61;
    localparam logic [7:0] ASCII_LC_HI = 8'h7A;
    localparam int         CASE_BIT    = 5;
    localparam logic [7:0] CASE_MASK   = 8'(1 << CASE_BIT);

endpackage

// File: rtl/case_conv_lane.sv
// case_conv_lane
// Combinational single-byte case converter. Only true letters are touched,
// and a letter is changed by flipping CASE_BIT alone, so bit 7 never moves.
//   i_byte     : input byte
//   i_mode     : conversion mode
//   o_byte     : converted byte
//   o_modified : 1 when o_byte differs from i_byte
module case_conv_lane
    import case_conv_pkg::*;
(
    input  logic [7:0]  i_byte,
    input  case_mode_t  i_mode,
    output logic [7:0]  o_byte,
    output logic        o_modified
);

    logic w_is_uc;
    logic w_is_lc;
    logic w_flip;

    assign w_is_uc = (i_byte >= ASCII_UC_LO) && (i_byte <= ASCII_UC_HI);
    assign w_is_lc = (i_byte >= ASCII_LC_LO) && (i_byte <= ASCII_LC_HI);

    always_comb begin
        w_flip = 1'b0;
        unique case (i_mode)
            MODE_UPPER:  w_flip = w_is_lc;
            MODE_LOWER:  w_flip = w_is_uc;
            MODE_TOGGLE: w_flip = w_is_uc | w_is_lc;
            default:     w_flip = 1'b0;
        endcase
    end

    assign o_byte     = w_flip ? (i_byte ^ CASE_MASK) : i_byte;
    assign o_modified = w_flip;

endmodule

// File: rtl/case_convert_stream.sv
// case_convert_stream
// Streaming ASCII case converter, LANES bytes per beat, valid/ready on both
// sides. Conversion happens on acceptance; the result sits in an output
// register backed by one skid register so full throughput survives
// backpressure without a combinational out_ready -> in_ready path.
//
// Optional feature macro: CASE_CONV_STATS_EN
//   defined   : saturating count of modified bytes on conv_count
//   undefined : conv_count tied to 0, count_clr ignored
//
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   mode                  : 00 pass, 01 upper, 10 lower, 11 toggle
//   in_valid/in_ready     : input handshake
//   in_data, in_last      : input beat (byte 0 at [7:0]) and end marker
//   out_valid/out_ready   : output handshake
//   out_data, out_last    : converted beat and delayed end marker
//   count_clr, conv_count : counter clear and value
module case_convert_stream
    import case_conv_pkg::*;
#(
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic                 out_last,
    input  logic                 count_clr,
    output logic [CNT_W-1:0]     conv_count
);

    logic [8*LANES-1:0] r_out_data;
    logic               r_out_last;
    logic               r_out_valid;
    logic [8*LANES-1:0] r_skid_data;
    logic               r_skid_last;
    logic               r_skid_full;

    logic [8*LANES-1:0] w_conv_data;
    logic [LANES-1:0]   w_mod;
    logic               w_accept;
    logic               w_emit;
    case_mode_t         w_mode;

    assign w_mode = case_mode_t'(mode);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        case_conv_lane u_lane (
            .i_byte     (in_data[8*g +: 8]),
            .i_mode     (w_mode),
            .o_byte     (w_conv_data[8*g +: 8]),
            .o_modified (w_mod[g])
        );
    end

    // rst_n gates in_ready so nothing is taken while reset is held.
    assign in_ready  = rst_n & ~r_skid_full;
    assign w_accept  = in_valid & in_ready;
    assign w_emit    = r_out_valid & out_ready;

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_skid_full <= 1'b0;
            r_skid_data <= '0;
            r_skid_last <= 1'b0;
        end else if (w_emit) begin
            // Skid full implies in_ready was low, so no accept can collide here.
            if (r_skid_full) begin
                r_out_data  <= r_skid_data;
                r_out_last  <= r_skid_last;
                r_skid_full <= 1'b0;
            end else if (w_accept) begin
                r_out_data  <= w_conv_data;
                r_out_last  <= in_last;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            if (!r_out_valid) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_conv_data;
                r_out_last  <= in_last;
            end else begin
                r_skid_full <= 1'b1;
                r_skid_data <= w_conv_data;
                r_skid_last <= in_last;
            end
        end
    end

`ifdef CASE_CONV_STATS_EN
    localparam int PC_W  = $clog2(LANES + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_count;
    logic [PC_W-1:0]  w_pop;
    logic [SUM_W-1:0] w_base;
    logic [SUM_W-1:0] w_sum;
    logic [CNT_W-1:0] w_count_next;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < LANES; i++) begin
            w_pop = w_pop + PC_W'(w_mod[i]);
        end
    end

    // A clear coinciding with an accept restarts from this beat's contribution.
    assign w_base       = count_clr ? '0 : SUM_W'(r_count);
    assign w_sum        = w_base + SUM_W'(w_pop);
    assign w_count_next = (w_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : w_sum[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= w_count_next;
        end else if (count_clr) begin
            r_count <= '0;
        end
    end

    assign conv_count = r_count;
`else
    logic w_unused_stats;
    assign w_unused_stats = ^{count_clr, w_mod};
    assign conv_count     = '0;
`endif

endmodule

// File: tb/tb_case_convert_stream.sv
module tb_case_convert_stream;

    localparam int LANES = 4;
    localparam int CNT_W = 4;
`ifdef CASE_CONV_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        mode;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic              out_last;
    logic              count_clr;
    logic [CNT_W-1:0]  conv_count;

    case_convert_stream #(.LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .count_clr  (count_clr),
        .conv_count (conv_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    exp_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] conv_ref(input logic [31:0] d, input logic [1:0] m);
        logic [31:0] r;
        logic [7:0]  b;
        logic        up, lo;
        for (int i = 0; i < 4; i++) begin
            b  = d[8*i +: 8];
            up = (b >= 8'h41) && (b <= 8'h5A);
            lo = (b >= 8'h61) && (b <= 8'h7A);
            case (m)
                2'b01: if (lo) b = b - 8'h20;
                2'b10: if (up) b = b + 8'h20;
                2'b11: begin
                    if (up)      b = b + 8'h20;
                    else if (lo) b = b - 8'h20;
                end
                default: ;
            endcase
            r[8*i +: 8] = b;
        end
        return r;
    endfunction

    function automatic int mods_ref(input logic [31:0] d, input logic [1:0] m);
        logic [31:0] r;
        int          n;
        r = conv_ref(d, m);
        n = 0;
        for (int i = 0; i < 4; i++) if (r[8*i +: 8] != d[8*i +: 8]) n++;
        return n;
    endfunction

    // Scoreboard: sample handshakes at the falling edge, i.e. for the next rising edge.
    always @(negedge clk) begin
        beat_t e;
        int    base;
        if (rst_n === 1'b1) begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("emit_unexpected", {31'b0, out_valid}, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("emit_data", out_data, e.data);
                    check("emit_last", {31'b0, out_last}, {31'b0, e.last});
                end
            end
            check("conv_count", {28'b0, conv_count}, exp_cnt);
            if (in_valid && in_ready) begin
                e.data = conv_ref(in_data, mode);
                e.last = in_last;
                q.push_back(e);
                if (STATS) begin
                    base    = count_clr ? 0 : exp_cnt;
                    exp_cnt = base + mods_ref(in_data, mode);
                    if (exp_cnt > 15) exp_cnt = 15;
                end
            end else if (count_clr) begin
                exp_cnt = 0;
            end
        end else begin
            q.delete();
            exp_cnt = 0;
        end
    end

    task automatic beat(input logic [1:0] m, input logic [31:0] d, input logic l);
        mode     = m;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        mode      = 2'b00;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        count_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_last", {31'b0, out_last}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_conv_count", {28'b0, conv_count}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("ready_after_rst", {31'b0, in_ready}, 32'd1);

        // Upper on "AZaz"
        beat(2'b01, 32'h7A615A41, 1'b1);
        in_valid = 1'b0;
        check("upper_valid", {31'b0, out_valid}, 32'd1);
        check("upper_data", out_data, 32'h5A415A41);
        check("upper_last", {31'b0, out_last}, 32'd1);
        check("upper_count", {28'b0, conv_count}, STATS ? 32'd2 : 32'd0);

        // Lower on letter-range neighbours: untouched
        beat(2'b10, 32'h7B605B40, 1'b0);
        in_valid = 1'b0;
        check("lower_edges_data", out_data, 32'h7B605B40);
        check("lower_edges_count", {28'b0, conv_count}, STATS ? 32'd2 : 32'd0);

        // Toggle, then pass on same data
        beat(2'b11, 32'h00316241, 1'b0);
        check("toggle_data", out_data, 32'h00314261);
        check("toggle_count", {28'b0, conv_count}, STATS ? 32'd4 : 32'd0);
        beat(2'b00, 32'h00316241, 1'b1);
        in_valid = 1'b0;
        check("pass_data", out_data, 32'h00316241);
        check("pass_count", {28'b0, conv_count}, STATS ? 32'd4 : 32'd0);

        // High bytes and mixed back-to-back beats at full rate
        beat(2'b11, 32'hC1E1DAFA, 1'b0);
        check("b2b_ready0", {31'b0, in_ready}, 32'd1);
        check("high_bytes_data", out_data, 32'hC1E1DAFA);
        beat(2'b01, 32'h6D5A2161, 1'b0);
        check("b2b_ready1", {31'b0, in_ready}, 32'd1);
        beat(2'b10, 32'h4D7A2141, 1'b1);
        check("b2b_valid", {31'b0, out_valid}, 32'd1);
        check("b2b_data", out_data, 32'h6D7A2161);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("drain_valid", {31'b0, out_valid}, 32'd0);

        // Backpressure: b1 -> OUT, b2 -> SKID, b3 stalls
        out_ready = 1'b0;
        beat(2'b01, 32'h64636261, 1'b0);
        check("bp_ready_after_b1", {31'b0, in_ready}, 32'd1);
        beat(2'b10, 32'h44434241, 1'b1);
        check("bp_ready_third", {31'b0, in_ready}, 32'd0);
        check("bp_hold_data", out_data, 32'h44434241);
        mode    = 2'b11;
        in_data = 32'h7A7A5A5A;
        in_last = 1'b0;
        @(posedge clk);
        #1;
        check("bp_hold_data2", out_data, 32'h44434241);
        check("bp_hold_last", {31'b0, out_last}, 32'd0);
        check("bp_still_stalled", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_ready_rise", {31'b0, in_ready}, 32'd1);
        check("bp_skid_to_out", out_data, 32'h64636261);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_b3_data", out_data, 32'h5A5A7A7A);
        @(posedge clk);
        #1;

        // Clear alone, saturation, clear together with an accept
        count_clr = 1'b1;
        @(posedge clk);
        #1;
        count_clr = 1'b0;
        check("clr_alone", {28'b0, conv_count}, 32'd0);
        for (int i = 0; i < 5; i++) beat(2'b01, 32'h64636261, 1'b0);
        in_valid = 1'b0;
        check("sat_count", {28'b0, conv_count}, STATS ? 32'd15 : 32'd0);
        count_clr = 1'b1;
        beat(2'b01, 32'h31326162, 1'b1);
        in_valid  = 1'b0;
        count_clr = 1'b0;
        check("clr_with_accept", {28'b0, conv_count}, STATS ? 32'd2 : 32'd0);
        check("clr_beat_data", out_data, 32'h31324142);
        @(posedge clk);
        #1;

        // Reset with OUT and SKID full discards both
        out_ready = 1'b0;
        beat(2'b01, 32'h61616161, 1'b0);
        beat(2'b01, 32'h62626262, 1'b1);
        in_valid = 1'b0;
        check("full_ready", {31'b0, in_ready}, 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_count", {28'b0, conv_count}, 32'd0);
        check("midrst_ready", {31'b0, in_ready}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("midrst_release_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_stale", {31'b0, out_valid}, 32'd0);

        // One more beat after reset to show the pipe restarts cleanly
        beat(2'b11, 32'h2E7A4121, 1'b1);
        in_valid = 1'b0;
        check("post_rst_data", out_data, 32'h2E5A6121);
        @(posedge clk);
        #1;
        check("sb_drained", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
